// File: rtl/rtc_multi_domain.sv
// rtc_multi_domain: PTP base clock (sec + fractional ns) with NUM_DOMAINS offset domains and per-domain 1PPS.
// Define RTC_CAPTURE_EN to add a synchronised event capture of domain 0 time.
module rtc_multi_domain #(
  parameter int NUM_DOMAINS = 4,
  parameter int FRAC_W = 24,
  parameter int PERIOD_INT_W = 8,
  parameter logic [PERIOD_INT_W+FRAC_W-1:0] DEFAULT_PERIOD = (PERIOD_INT_W+FRAC_W)'(8) << FRAC_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic time_ld,
  input  logic [29:0] time_ns_in,
  input  logic [47:0] time_sec_in,
  input  logic period_ld,
  input  logic [PERIOD_INT_W+FRAC_W-1:0] period_in,
  input  logic adj_ld,
  input  logic [31:0] adj_cnt,
  input  logic [PERIOD_INT_W+FRAC_W-1:0] period_adj,
  output logic adj_done,
  input  logic offset_ld,
  input  logic [(NUM_DOMAINS>1 ? $clog2(NUM_DOMAINS) : 1)-1:0] offset_dom,
  input  logic [29:0] offset_ns_in,
  input  logic [47:0] offset_sec_in,
  output logic offset_err,
  output logic [30+FRAC_W-1:0] base_ns,
  output logic [47:0] base_sec,
  output logic base_pps,
  output logic [NUM_DOMAINS*30-1:0] dom_ns,
  output logic [NUM_DOMAINS*48-1:0] dom_sec,
  output logic [NUM_DOMAINS-1:0] dom_pps
`ifdef RTC_CAPTURE_EN
  ,
  input  logic evt_in,
  output logic [29:0] cap_ns,
  output logic [47:0] cap_sec,
  output logic cap_vld
`endif
);
  localparam int PW = PERIOD_INT_W + FRAC_W;
  localparam int NW = 30 + FRAC_W;
  localparam int DW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [NW:0] ONE_SEC = (NW+1)'(1_000_000_000) << FRAC_W;
  localparam logic [30:0] NS_MAX = 31'd1_000_000_000;
  typedef enum logic {IDLE, ADJ} state_t;
  state_t state_q;
  logic [31:0] cnt_q;
  logic [PW-1:0] padj_q, period_q, period_d, inc;
  logic [NW-1:0] ns_q, ns_d;
  logic [NW:0] sum;
  logic roll, pps_q, pps_d, adj_done_q, tld_q, err_q, err_d, off_ok;
  logic [47:0] sec_q, sec_d;
  logic [29:0] off_ns_q [NUM_DOMAINS];
  logic [29:0] off_ns_d [NUM_DOMAINS];
  logic [47:0] off_sec_q [NUM_DOMAINS];
  logic [47:0] off_sec_d [NUM_DOMAINS];
  logic [30:0] nsum [NUM_DOMAINS];
  logic [29:0] dns_q [NUM_DOMAINS];
  logic [29:0] dns_d [NUM_DOMAINS];
  logic [47:0] dsec_q [NUM_DOMAINS];
  logic [47:0] dsec_d [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] carry, ol_q, ol_d, dpps_q, dpps_d;
  always_comb begin
    inc = state_q == ADJ ? padj_q : period_q;
    sum = {1'b0, ns_q} + (NW+1)'(inc);
    roll = sum >= ONE_SEC;
    ns_d = time_ld ? {time_ns_in, {FRAC_W{1'b0}}} : NW'(roll ? sum - ONE_SEC : sum);
    sec_d = time_ld ? time_sec_in : sec_q + 48'(roll);
    pps_d = !time_ld && roll;
    period_d = period_ld ? period_in : period_q;
    err_d = offset_ld && (offset_ns_in >= 30'd1_000_000_000 || 32'(offset_dom) >= NUM_DOMAINS);
    off_ok = offset_ld && !err_d;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      ol_d[d] = off_ok && offset_dom == DW'(d);
      off_ns_d[d] = ol_d[d] ? offset_ns_in : off_ns_q[d];
      off_sec_d[d] = ol_d[d] ? offset_sec_in : off_sec_q[d];
      // Domains track the registered base, so they lag it by one cycle and drop the fraction
      nsum[d] = {1'b0, ns_q[NW-1:FRAC_W]} + {1'b0, off_ns_q[d]};
      carry[d] = nsum[d] >= NS_MAX;
      dns_d[d] = 30'(carry[d] ? nsum[d] - NS_MAX : nsum[d]);
      dsec_d[d] = sec_q + off_sec_q[d] + 48'(carry[d]);
      dpps_d[d] = dsec_d[d] == dsec_q[d] + 48'd1 && !tld_q && !ol_q[d];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_q <= '0;
      sec_q <= '0;
      pps_q <= 1'b0;
      period_q <= DEFAULT_PERIOD;
      tld_q <= 1'b0;
      err_q <= 1'b0;
      ol_q <= '0;
      dpps_q <= '0;
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        off_ns_q[d] <= '0;
        off_sec_q[d] <= '0;
        dns_q[d] <= '0;
        dsec_q[d] <= '0;
      end
    end else begin
      ns_q <= ns_d;
      sec_q <= sec_d;
      pps_q <= pps_d;
      period_q <= period_d;
      tld_q <= time_ld;
      err_q <= err_d;
      ol_q <= ol_d;
      dpps_q <= dpps_d;
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        off_ns_q[d] <= off_ns_d[d];
        off_sec_q[d] <= off_sec_d[d];
        dns_q[d] <= dns_d[d];
        dsec_q[d] <= dsec_d[d];
      end
    end
  end
  // A new adj_ld always restarts the count, even mid-adjustment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      padj_q <= '0;
      adj_done_q <= 1'b0;
    end else begin
      adj_done_q <= 1'b0;
      if (adj_ld) begin
        padj_q <= period_adj;
        cnt_q <= adj_cnt;
        state_q <= adj_cnt == '0 ? IDLE : ADJ;
        adj_done_q <= adj_cnt == '0;
      end else if (state_q == ADJ) begin
        cnt_q <= cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_q <= IDLE;
          adj_done_q <= 1'b1;
        end
      end
    end
  end
  assign base_ns = ns_q;
  assign base_sec = sec_q;
  assign base_pps = pps_q;
  assign adj_done = adj_done_q;
  assign offset_err = err_q;
  assign dom_pps = dpps_q;
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    assign dom_ns[30*g+:30] = dns_q[g];
    assign dom_sec[48*g+:48] = dsec_q[g];
  end
`ifdef RTC_CAPTURE_EN
  logic [2:0] evt_q;
  logic cap_vld_q;
  logic [29:0] cap_ns_q;
  logic [47:0] cap_sec_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
      cap_vld_q <= 1'b0;
      cap_ns_q <= '0;
      cap_sec_q <= '0;
    end else begin
      evt_q <= {evt_q[1:0], evt_in};
      cap_vld_q <= evt_q[1] & ~evt_q[2];
      if (evt_q[1] & ~evt_q[2]) begin
        cap_ns_q <= dns_q[0];
        cap_sec_q <= dsec_q[0];
      end
    end
  end
  assign cap_ns = cap_ns_q;
  assign cap_sec = cap_sec_q;
  assign cap_vld = cap_vld_q;
`endif
endmodule

// File: tb/tb_rtc_multi_domain.sv
// tb_rtc_multi_domain: directed checks of base stepping, loads, offsets, adjustment and reset abort.
module tb_rtc_multi_domain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic time_ld = 1'b0;
  logic [29:0] time_ns_in = '0;
  logic [47:0] time_sec_in = '0;
  logic period_ld = 1'b0;
  logic [31:0] period_in = '0;
  logic adj_ld = 1'b0;
  logic [31:0] adj_cnt = '0;
  logic [31:0] period_adj = '0;
  logic adj_done;
  logic offset_ld = 1'b0;
  logic [1:0] offset_dom = '0;
  logic [29:0] offset_ns_in = '0;
  logic [47:0] offset_sec_in = '0;
  logic offset_err;
  logic [53:0] base_ns;
  logic [47:0] base_sec;
  logic base_pps;
  logic [119:0] dom_ns;
  logic [191:0] dom_sec;
  logic [3:0] dom_pps;
`ifdef RTC_CAPTURE_EN
  logic evt_in = 1'b0;
  logic [29:0] cap_ns;
  logic [47:0] cap_sec;
  logic cap_vld;
`endif
  int total = 0;
  int bad = 0;

  rtc_multi_domain dut (
    .clk(clk), .rst_n(rst_n), .time_ld(time_ld), .time_ns_in(time_ns_in), .time_sec_in(time_sec_in),
    .period_ld(period_ld), .period_in(period_in), .adj_ld(adj_ld), .adj_cnt(adj_cnt),
    .period_adj(period_adj), .adj_done(adj_done), .offset_ld(offset_ld), .offset_dom(offset_dom),
    .offset_ns_in(offset_ns_in), .offset_sec_in(offset_sec_in), .offset_err(offset_err),
    .base_ns(base_ns), .base_sec(base_sec), .base_pps(base_pps), .dom_ns(dom_ns), .dom_sec(dom_sec),
    .dom_pps(dom_pps)
`ifdef RTC_CAPTURE_EN
    , .evt_in(evt_in), .cap_ns(cap_ns), .cap_sec(cap_sec), .cap_vld(cap_vld)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({base_ns, base_sec, dom_ns, dom_sec} !== '0) begin
      $display("FAIL reset_time got ns=%0h sec=%0h dns=%0h dsec=%0h exp 0", base_ns, base_sec, dom_ns, dom_sec);
      bad++;
    end
    total++;
    if ({base_pps, dom_pps, adj_done, offset_err} !== 7'd0) begin
      $display("FAIL reset_flags got %b exp 0", {base_pps, dom_pps, adj_done, offset_err});
      bad++;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (base_ns !== (54'(8 * k) << 24)) begin
        $display("FAIL step_base k=%0d got %0h exp %0h", k, base_ns, 54'(8 * k) << 24);
        bad++;
      end
      for (int d = 0; d < 4; d++) begin
        total++;
        if (dom_ns[30*d+:30] !== 30'(8 * (k - 1)) || dom_sec[48*d+:48] !== 48'd0) begin
          $display("FAIL step_dom k=%0d d=%0d got %0d/%0d exp %0d/0", k, d, dom_ns[30*d+:30], dom_sec[48*d+:48], 8 * (k - 1));
          bad++;
        end
      end
    end
  endtask

  task automatic test_time_ld();
    time_ld = 1'b1; time_ns_in = 30'd999999992; time_sec_in = 48'd5;
    tick();
    time_ld = 1'b0;
    total++;
    if (base_ns[53:24] !== 30'd999999992 || base_sec !== 48'd5 || base_pps !== 1'b0) begin
      $display("FAIL tld_load got %0d/%0d pps=%b exp 999999992/5 pps=0", base_ns[53:24], base_sec, base_pps);
      bad++;
    end
    tick();
    total++;
    if (base_ns !== 54'd0 || base_sec !== 48'd6 || base_pps !== 1'b1) begin
      $display("FAIL tld_roll got %0h/%0d pps=%b exp 0/6 pps=1", base_ns, base_sec, base_pps);
      bad++;
    end
    total++;
    if (dom_ns[29:0] !== 30'd999999992 || dom_pps !== 4'd0) begin
      $display("FAIL tld_dom_lag got %0d pps=%b exp 999999992 pps=0000", dom_ns[29:0], dom_pps);
      bad++;
    end
    tick();
    total++;
    if (base_pps !== 1'b0 || dom_ns[29:0] !== 30'd0 || dom_sec[47:0] !== 48'd6 || dom_pps !== 4'hF) begin
      $display("FAIL tld_dom_pps got bpps=%b %0d/%0d pps=%b exp 0 0/6 1111", base_pps, dom_ns[29:0], dom_sec[47:0], dom_pps);
      bad++;
    end
    tick();
    total++;
    if (dom_pps !== 4'd0) begin
      $display("FAIL tld_pps_end got %b exp 0000", dom_pps);
      bad++;
    end
  endtask

  task automatic test_offset();
    time_ld = 1'b1; time_ns_in = 30'd0; time_sec_in = 48'h10;
    offset_ld = 1'b1; offset_dom = 2'd1; offset_ns_in = 30'd999999999; offset_sec_in = 48'd0;
    tick();
    time_ld = 1'b0; offset_ld = 1'b0;
    tick();
    total++;
    if (dom_ns[59:30] !== 30'd999999999 || dom_sec[95:48] !== 48'h10) begin
      $display("FAIL off_both got %0d/%0h exp 999999999/10", dom_ns[59:30], dom_sec[95:48]);
      bad++;
    end
    tick();
    total++;
    if (dom_ns[59:30] !== 30'd7 || dom_sec[95:48] !== 48'h11 || dom_pps !== 4'b0010) begin
      $display("FAIL off_carry got %0d/%0h pps=%b exp 7/11 pps=0010", dom_ns[59:30], dom_sec[95:48], dom_pps);
      bad++;
    end
    offset_ld = 1'b1; offset_dom = 2'd2; offset_ns_in = 30'd0; offset_sec_in = 48'hFFFF_FFFF_FFFF;
    tick();
    offset_ld = 1'b0;
    tick();
    total++;
    if (dom_ns[89:60] !== 30'd24 || dom_sec[143:96] !== 48'hF || dom_pps[2] !== 1'b0) begin
      $display("FAIL off_neg got %0d/%0h pps=%b exp 24/f pps=0", dom_ns[89:60], dom_sec[143:96], dom_pps[2]);
      bad++;
    end
    offset_ld = 1'b1; offset_dom = 2'd2; offset_ns_in = 30'd1000000000; offset_sec_in = 48'd5;
    tick();
    offset_ld = 1'b0;
    total++;
    if (offset_err !== 1'b1) begin
      $display("FAIL off_err got %b exp 1", offset_err);
      bad++;
    end
    tick();
    total++;
    if (offset_err !== 1'b0 || dom_ns[89:60] !== 30'd40 || dom_sec[143:96] !== 48'hF) begin
      $display("FAIL off_drop got err=%b %0d/%0h exp err=0 40/f", offset_err, dom_ns[89:60], dom_sec[143:96]);
      bad++;
    end
  endtask

  task automatic test_adjust();
    int exp_ns [5] = '{8, 17, 26, 35, 43};
    logic exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    time_ld = 1'b1; time_ns_in = 30'd0; time_sec_in = 48'd1;
    tick();
    time_ld = 1'b0;
    adj_ld = 1'b1; adj_cnt = 32'd3; period_adj = 32'd9 << 24;
    for (int i = 0; i < 5; i++) begin
      tick();
      adj_ld = 1'b0;
      total++;
      if (base_ns !== (54'(exp_ns[i]) << 24) || adj_done !== exp_done[i]) begin
        $display("FAIL adj3 i=%0d got %0d done=%b exp %0d done=%b", i, base_ns[53:24], adj_done, exp_ns[i], exp_done[i]);
        bad++;
      end
    end
    adj_ld = 1'b1; adj_cnt = 32'd0;
    tick();
    adj_ld = 1'b0;
    total++;
    if (adj_done !== 1'b1 || base_ns !== (54'd51 << 24)) begin
      $display("FAIL adj0 got done=%b ns=%0d exp done=1 ns=51", adj_done, base_ns[53:24]);
      bad++;
    end
    tick();
    total++;
    if (adj_done !== 1'b0 || base_ns !== (54'd59 << 24)) begin
      $display("FAIL adj0_end got done=%b ns=%0d exp done=0 ns=59", adj_done, base_ns[53:24]);
      bad++;
    end
  endtask

  task automatic test_period();
    int exp_ns [7] = '{0, 9, 18, 28, 38, 48, 56};
    logic exp_done [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    time_ld = 1'b1; time_ns_in = 30'd0; time_sec_in = 48'd1;
    adj_ld = 1'b1; adj_cnt = 32'd2; period_adj = 32'd9 << 24;
    for (int i = 0; i < 7; i++) begin
      tick();
      time_ld = 1'b0; adj_ld = 1'b0;
      period_ld = i == 0 || i == 4;
      period_in = i == 0 ? 32'd10 << 24 : 32'd8 << 24;
      total++;
      if (base_ns !== (54'(exp_ns[i]) << 24) || adj_done !== exp_done[i]) begin
        $display("FAIL period i=%0d got %0d done=%b exp %0d done=%b", i, base_ns[53:24], adj_done, exp_ns[i], exp_done[i]);
        bad++;
      end
    end
    period_ld = 1'b0;
  endtask

  task automatic test_sec_wrap();
    time_ld = 1'b1; time_ns_in = 30'd999999992; time_sec_in = 48'hFFFF_FFFF_FFFF;
    tick();
    time_ld = 1'b0;
    tick();
    total++;
    if (base_ns !== 54'd0 || base_sec !== 48'd0 || base_pps !== 1'b1) begin
      $display("FAIL wrap_base got %0h/%0h pps=%b exp 0/0 pps=1", base_ns, base_sec, base_pps);
      bad++;
    end
    tick();
    total++;
    if (dom_sec[47:0] !== 48'd0 || dom_pps[0] !== 1'b1) begin
      $display("FAIL wrap_dom got %0h pps=%b exp 0 pps=1", dom_sec[47:0], dom_pps[0]);
      bad++;
    end
  endtask

  task automatic test_reset_adj();
    adj_ld = 1'b1; adj_cnt = 32'd5; period_adj = 32'd9 << 24;
    tick();
    adj_ld = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (base_ns !== 54'd0 || base_sec !== 48'd0 || dom_sec !== '0) begin
      $display("FAIL async_rst got %0h/%0h exp 0/0", base_ns, base_sec);
      bad++;
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (adj_done !== 1'b0 || base_ns !== (54'(8 * k) << 24)) begin
        $display("FAIL rst_abort k=%0d got done=%b ns=%0d exp done=0 ns=%0d", k, adj_done, base_ns[53:24], 8 * k);
        bad++;
      end
    end
  endtask

`ifdef RTC_CAPTURE_EN
  task automatic test_capture();
    time_ld = 1'b1; time_ns_in = 30'd800; time_sec_in = 48'd2;
    tick();
    time_ld = 1'b0;
    evt_in = 1'b1;
    tick();
    tick();
    total++;
    if (cap_vld !== 1'b0) begin
      $display("FAIL cap_early got %b exp 0", cap_vld);
      bad++;
    end
    tick();
    total++;
    if (cap_vld !== 1'b1 || cap_ns !== 30'd808 || cap_sec !== 48'd2) begin
      $display("FAIL cap_val got vld=%b %0d/%0d exp 1 808/2", cap_vld, cap_ns, cap_sec);
      bad++;
    end
    tick();
    evt_in = 1'b0;
    total++;
    if (cap_vld !== 1'b0) begin
      $display("FAIL cap_pulse got %b exp 0", cap_vld);
      bad++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_time_ld();
    test_offset();
    test_adjust();
    test_period();
    test_sec_wrap();
    test_reset_adj();
`ifdef RTC_CAPTURE_EN
    test_capture();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
